mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the 5-stage RISC-V pipeline against a variable-latency data memory with a req/ready + rvalid handshake.
- Freezes the upstream pipeline registers and bubbles MEM/WB while an access is outstanding.
- Performs byte-lane steering for stores and sign/zero extension for loads.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before bus-error abort (1..65535)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
MemReadM  in  1  load in MEM stage
MemWriteM  in  1  store in MEM stage
funct3M  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
ALUResultM  in  32  byte address
WriteDataM  in  32  store data (low bits valid)
dmem_req  out  1  request valid
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-steered store data
dmem_be  out  4  byte enables
dmem_ready  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data word
ReadDataM  out  32  extended load result to MEM/WB
StallMem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
BubbleW  out  1  force RegWrite=0 into MEM/WB (equal to StallMem)
bus_error  out  1  one-cycle pulse on timeout abort

Behaviour:
- States: IDLE, REQ, WAIT, RESP. All outputs are registered or decoded from state. No dmem_* input reaches an output combinationally.
- Reset values: state IDLE, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, dmem_be 0, ReadDataM 0, bus_error 0, timeout counter 0.
- StallMem is 1 when (state==IDLE and (MemReadM|MemWriteM)), or in REQ or WAIT. It is 0 in RESP and in IDLE with no access.
- IDLE:
  - With no access: pass through with no stall.
  - With an access: latch addr, we (=~MemReadM; read wins if both are high), wdata, be and funct3, then go to REQ.
- REQ:
  - dmem_req=1. Hold all request fields stable until dmem_ready.
  - On ready with a write, go to RESP (a store completes on acceptance).
  - On ready with a read, go to WAIT.
- WAIT: on dmem_rvalid, capture the extended data into ReadDataM, then go to RESP. dmem_req=0.
- RESP:
  - StallMem=0; the instruction advances and MEM/WB latches ReadDataM.
  - Next state is IDLE. IDLE must not re-trigger on the same instruction, because the next instruction is already in M.
- Minimum MEM-stage residency: store 3 cycles (ready in the first REQ cycle); load 4 cycles (rvalid the cycle after ready).
- Store steering:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{wd[15:0]}}.
  - SW: be=4'b1111.
- Load extension: select the lane by addr[1:0] (or addr[1] for halfwords). B/H sign-extend; BU/HU zero-extend; W passes through.
- Undefined funct3 is treated as W.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the count reaches TIMEOUT_CYCLES-1 without completion: go to RESP, pulse bus_error for one cycle, ReadDataM=0, dmem_req deasserts.
- dmem_rvalid outside WAIT is ignored. A late rvalid after an abort or reset is ignored.
- Reset mid-operation: at the next edge the state returns to IDLE and dmem_req=0. There is no retry.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined:
  - Misaligned accesses (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) issue no dmem_req.
  - IDLE goes directly to RESP, with an added output misalign_fault (1 bit) pulsed for the RESP cycle and ReadDataM=0.
  - Stall lasts exactly 1 cycle.
- Undefined: the misalign_fault port is absent. Offending low address bits are ignored (halfword uses addr[1], word uses lane 0), and the access proceeds normally.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, ready in first REQ cycle -> dmem_be=1111, dmem_addr=0x100, StallMem high 2 cycles, RESP on cycle 3.
- LB addr 0x103, rdata 0x80FF_0000 with rvalid 3 cycles after ready -> ReadDataM=0xFFFFFF80, StallMem high throughout WAIT, BubbleW matches.
- SH addr 0x202 data 0x0000_1234 -> be=1100, wdata=0x12341234; LHU from same word with rdata 0x1234_5678 -> ReadDataM=0x00001234.
- TIMEOUT_CYCLES=8, dmem_ready held low -> bus_error pulses once after 8 REQ cycles, ReadDataM=0, dmem_req drops, pipeline resumes.
- Assert reset while in WAIT -> next cycle state IDLE, dmem_req=0, StallMem=0; a subsequent rvalid is ignored.
- Back-to-back LW then non-memory instruction -> second instruction sees no stall; with MISALIGN_TRAP_EN, LW at 0x101 -> misalign_fault for 1 cycle, no dmem_req.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Sequences MEM-stage data-memory accesses of the 5-stage RISC-V pipeline
//   against a variable-latency memory using a req/ready request handshake and
//   an rvalid read-data return. While an access is outstanding the upstream
//   pipeline registers are frozen and MEM/WB receives a bubble. Stores are
//   byte-lane steered; loads are sign/zero extended before reaching MEM/WB.
//
//   Optional build macro: MISALIGN_TRAP_EN
//     defined   : misaligned H/W accesses skip the bus, pulse misalign_fault
//     undefined : offending low address bits are ignored, access proceeds
//
// Parameters
//   TIMEOUT_CYCLES  max cycles in REQ+WAIT before a bus-error abort (1..65535)
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   MemReadM, MemWriteM          load / store present in MEM
//   funct3M                      size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   ALUResultM, WriteDataM       byte address, store data
//   dmem_req/we/addr/wdata/be    request channel to data memory
//   dmem_ready                   request accepted this cycle
//   dmem_rvalid, dmem_rdata      read data return
//   ReadDataM                    extended load result to MEM/WB
//   StallMem, BubbleW            freeze upstream / bubble MEM/WB
//   misalign_fault               (MISALIGN_TRAP_EN only) misaligned access pulse
//   bus_error                    one-cycle pulse on timeout abort
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallMem,
    output logic        BubbleW,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_fault,
`endif
    output logic        bus_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_offset;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [2:0]  r_funct3;
    logic [15:0] r_count;
    logic [31:0] r_read_data;
    logic        r_bus_error;

    logic        w_access;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_busy;
    logic        w_done;
    logic        w_abort;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load_ext;

    // Request decode from the EX/MEM outputs; only consumed in IDLE.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_access  = MemReadM | MemWriteM;
        w_is_byte = (funct3M[1:0] == 2'b00);
        w_is_half = (funct3M[1:0] == 2'b01);
        w_be      = 4'b1111;
        w_wdata   = WriteDataM;
        if (w_is_byte) begin
            w_be    = 4'b0001 << ALUResultM[1:0];
            w_wdata = {4{WriteDataM[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << {ALUResultM[1], 1'b0};
            w_wdata = {2{WriteDataM[15:0]}};
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Undefined funct3 encodings count as word accesses.
    assign w_misaligned = (w_is_half & ALUResultM[0]) |
                          (~w_is_byte & ~w_is_half & (ALUResultM[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Load lane select and extension, using the offset latched in IDLE.
    always_comb begin
        w_lane_b = dmem_rdata[7:0];
        case (r_offset)
            2'd1:    w_lane_b = dmem_rdata[15:8];
            2'd2:    w_lane_b = dmem_rdata[23:16];
            2'd3:    w_lane_b = dmem_rdata[31:24];
            default: w_lane_b = dmem_rdata[7:0];
        endcase
        w_lane_h = r_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3[1:0])
            2'b00:   w_load_ext = r_funct3[2] ? {24'h0, w_lane_b}
                                              : {{24{w_lane_b[7]}}, w_lane_b};
            2'b01:   w_load_ext = r_funct3[2] ? {16'h0, w_lane_h}
                                              : {{16{w_lane_h[15]}}, w_lane_h};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    // A store finishes on acceptance, a load on rvalid. The timeout only
    // fires on the final budgeted cycle if neither happened, so a read
    // accepted on that cycle is still aborted (its data could never arrive).
    always_comb begin
        w_busy  = (r_state == S_REQ) || (r_state == S_WAIT);
        w_done  = ((r_state == S_REQ) && dmem_ready && r_we) ||
                  ((r_state == S_WAIT) && dmem_rvalid);
        w_abort = w_busy && !w_done && (r_count == LAST_COUNT);

        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_access) w_next_state = w_misaligned ? S_RESP : S_REQ;
            S_REQ: begin
                if (w_done || w_abort)   w_next_state = S_RESP;
                else if (dmem_ready)     w_next_state = S_WAIT;
            end
            S_WAIT: if (w_done || w_abort) w_next_state = S_RESP;
            // RESP always returns to IDLE, where the next instruction is seen.
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_offset    <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_funct3    <= '0;
            r_count     <= '0;
            r_read_data <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_bus_error <= w_abort;
            if (r_state == S_IDLE && w_access) begin
                r_we     <= ~MemReadM;
                r_addr   <= {ALUResultM[31:2], 2'b00};
                r_offset <= ALUResultM[1:0];
                r_wdata  <= w_wdata;
                r_be     <= w_be;
                r_funct3 <= funct3M;
                r_count  <= '0;
                if (w_misaligned) r_read_data <= '0;
            end
            if (w_busy) r_count <= r_count + 16'd1;
            if (r_state == S_WAIT && dmem_rvalid) r_read_data <= w_load_ext;
            else if (w_abort)                     r_read_data <= '0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_misalign_fault;

    always_ff @(posedge clk) begin
        if (reset) r_misalign_fault <= 1'b0;
        else       r_misalign_fault <= (r_state == S_IDLE) && w_access && w_misaligned;
    end

    assign misalign_fault = r_misalign_fault;
`endif

    assign dmem_req   = (r_state == S_REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign ReadDataM  = r_read_data;
    assign bus_error  = r_bus_error;
    assign StallMem   = ((r_state == S_IDLE) && w_access) || w_busy;
    assign BubbleW    = StallMem;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Drives one MEM-stage instruction at a time, holding it while StallMem is
//   expected high. Memory responses follow a precomputed per-instruction
//   schedule (ready delay, rvalid delay), so expected outputs for every cycle
//   come from the access rules and a word-array memory model, not from DUT
//   feedback. A negedge compare process checks every cycle.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] ReadDataM;
    logic        StallMem, BubbleW, bus_error;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_fault;
    logic        exp_fault;
    int          obs_fault;
`endif

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ready (dmem_ready),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .ReadDataM  (ReadDataM),
        .StallMem   (StallMem),
        .BubbleW    (BubbleW),
`ifdef MISALIGN_TRAP_EN
        .misalign_fault(misalign_fault),
`endif
        .bus_error  (bus_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle, written by the stimulus process.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_berr;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;
    int          obs_stall, obs_berr;

    logic [31:0] mem [256];

    always @(negedge clk) begin
        if (chk_en) begin
            check("StallMem",  {31'b0, StallMem},  {31'b0, exp_stall});
            check("BubbleW",   {31'b0, BubbleW},   {31'b0, exp_stall});
            check("dmem_req",  {31'b0, dmem_req},  {31'b0, exp_req});
            check("bus_error", {31'b0, bus_error}, {31'b0, exp_berr});
            check("ReadDataM", ReadDataM, exp_rd);
            if (exp_req) begin
                check("dmem_addr", dmem_addr, exp_addr);
                check("dmem_we",   {31'b0, dmem_we}, {31'b0, exp_we});
                if (exp_we) begin
                    check("dmem_be",    {28'b0, dmem_be}, {28'b0, exp_be});
                    check("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end
`ifdef MISALIGN_TRAP_EN
            check("misalign_fault", {31'b0, misalign_fault}, {31'b0, exp_fault});
            if (misalign_fault) obs_fault++;
`endif
            if (StallMem)  obs_stall++;
            if (bus_error) obs_berr++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        dmem_rvalid = ($urandom_range(0, 3) == 0);
        dmem_rdata  = $urandom;
    endtask

    // One instruction in MEM. d_r: ready-low cycles before acceptance;
    // d_v: WAIT cycles before rvalid.
    task automatic do_instr(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int d_r, input int d_v);
        int          size, nreq, nbusy, idx;
        bit          complete, misal;
        logic [31:0] word, ext, swd;
        logic [3:0]  be;
        logic [7:0]  b8;
        logic [15:0] h16;

        obs_stall = 0;
        obs_berr  = 0;
`ifdef MISALIGN_TRAP_EN
        obs_fault = 0;
        exp_fault = 1'b0;
`endif
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        dmem_ready = 1'b0;
        exp_berr   = 1'b0;
        exp_req    = 1'b0;
        noise();

        if (!(rd | wr)) begin
            exp_stall = 1'b0;
            step();
        end else begin
            size = (f3[1:0] == 2'b00) ? 0 : (f3[1:0] == 2'b01) ? 1 : 2;
            idx  = int'(addr[9:2]);
            word = mem[idx];
            case (size)
                0:       begin be = 4'b0001 << addr[1:0]; swd = {4{wd[7:0]}}; end
                1:       begin be = addr[1] ? 4'b1100 : 4'b0011; swd = {2{wd[15:0]}}; end
                default: begin be = 4'b1111; swd = wd; end
            endcase
            b8  = word[int'(addr[1:0]) * 8 +: 8];
            h16 = word[int'(addr[1]) * 16 +: 16];
            case (size)
                0:       ext = f3[2] ? {24'h0, b8}  : {{24{b8[7]}}, b8};
                1:       ext = f3[2] ? {16'h0, h16} : {{16{h16[15]}}, h16};
                default: ext = word;
            endcase
`ifdef MISALIGN_TRAP_EN
            misal = (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00);
`else
            misal = 1'b0;
`endif
            // IDLE cycle: request seen, stall asserted combinationally.
            exp_stall = 1'b1;
            step();

            if (misal) begin
                noise();
                exp_stall = 1'b0;
                exp_rd    = 32'h0;
`ifdef MISALIGN_TRAP_EN
                exp_fault = 1'b1;
`endif
                step();
            end else begin
                if (rd) complete = (d_r + d_v + 2 <= T);
                else    complete = (d_r + 1 <= T);
                nbusy     = complete ? (rd ? d_r + d_v + 2 : d_r + 1) : T;
                nreq      = (d_r + 1 < T) ? d_r + 1 : T;
                exp_addr  = {addr[31:2], 2'b00};
                exp_we    = !rd;
                exp_be    = be;
                exp_wdata = swd;
                for (int t = 0; t < nbusy; t++) begin
                    exp_stall  = 1'b1;
                    exp_req    = (t < nreq);
                    dmem_ready = (t == d_r);
                    if (rd && t == d_r + 1 + d_v) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = word;
                    end else if (rd && t > d_r) begin
                        dmem_rvalid = 1'b0;
                        dmem_rdata  = $urandom;
                    end else begin
                        noise();
                    end
                    step();
                end
                // RESP cycle
                dmem_ready = 1'b0;
                noise();
                exp_stall = 1'b0;
                exp_req   = 1'b0;
                exp_berr  = !complete;
                if (!complete) exp_rd = 32'h0;
                else if (rd)   exp_rd = ext;
                else begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) word[b*8 +: 8] = swd[b*8 +: 8];
                    mem[idx] = word;
                end
                step();
            end
        end
    endtask

    logic [2:0] sf3 [6];
    int         kind, dr, dv;
    logic [2:0] f3r;

    initial begin
        sf3[0] = 3'b000; sf3[1] = 3'b001; sf3[2] = 3'b010;
        sf3[3] = 3'b011; sf3[4] = 3'b110; sf3[5] = 3'b111;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        reset = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_berr = 1'b0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_rd = 32'h0; exp_be = 4'h0;
`ifdef MISALIGN_TRAP_EN
        exp_fault = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        check("reset_dmem_addr",  dmem_addr, 32'h0);
        check("reset_dmem_wdata", dmem_wdata, 32'h0);
        check("reset_dmem_be",    {28'b0, dmem_be}, 32'h0);
        reset = 1'b0;

        // SW 0x100, accepted in the first REQ cycle.
        do_instr(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
        check("sw_stall_cycles", 32'(obs_stall), 32'd2);
        check("sw_addr",  dmem_addr, 32'h100);
        check("sw_be",    {28'b0, dmem_be}, 32'hF);
        check("sw_wdata", dmem_wdata, 32'hDEADBEEF);

        // LB 0x103 from word 0x80FF0000, rvalid 3 cycles after ready.
        do_instr(1'b0, 1'b1, 3'b010, 32'h100, 32'h80FF0000, 1, 0);
        do_instr(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 2);
        check("lb_result", ReadDataM, 32'hFFFFFF80);
        check("lb_stall_cycles", 32'(obs_stall), 32'd5);

        // SH 0x202 then LHU 0x202.
        do_instr(1'b0, 1'b1, 3'b010, 32'h200, 32'h12345678, 0, 0);
        do_instr(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 0, 0);
        check("sh_be",    {28'b0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'h12341234);
        do_instr(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 1, 1);
        check("lhu_result", ReadDataM, 32'h00001234);

        // Ready held low: abort after T REQ cycles.
        do_instr(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 100, 0);
        check("timeout_berr_pulses",  32'(obs_berr), 32'd1);
        check("timeout_stall_cycles", 32'(obs_stall), 32'(T + 1));
        check("timeout_result", ReadDataM, 32'h0);
        do_instr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0);
        check("after_timeout_stall", 32'(obs_stall), 32'd0);

        // LW then a non-memory instruction.
        do_instr(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 0, 0);
        do_instr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0);
        check("nop_after_lw_stall", 32'(obs_stall), 32'd0);

`ifdef MISALIGN_TRAP_EN
        do_instr(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0);
        check("misalign_stall_cycles", 32'(obs_stall), 32'd1);
        check("misalign_pulses", 32'(obs_fault), 32'd1);
`endif

        // Reset while in WAIT; a later rvalid must be ignored.
        MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010;
        ALUResultM = 32'h500; dmem_rvalid = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_berr = 1'b0;
        step();                                        // IDLE
        exp_req = 1'b1; exp_addr = 32'h500; exp_we = 1'b0;
        dmem_ready = 1'b1;
        step();                                        // REQ, accepted
        dmem_ready = 1'b0; exp_req = 1'b0; reset = 1'b1;
        step();                                        // WAIT, reset sampled
        reset = 1'b0; MemReadM = 1'b0;
        exp_stall = 1'b0; exp_rd = 32'h0;
        step();                                        // back in IDLE
        check("reset_mid_addr", dmem_addr, 32'h0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5A5A5;
        step();                                        // late rvalid
        dmem_rvalid = 1'b0;
        step();

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            dr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
            dv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8)  : $urandom_range(0, 2);
            if (kind < 3) begin
                do_instr(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 0, 0);
            end else if (kind < 6) begin
                do_instr(1'b1, 1'b0, 3'($urandom), $urandom, $urandom, dr, dv);
            end else if (kind < 9) begin
                f3r = sf3[$urandom_range(0, 5)];
                do_instr(1'b0, 1'b1, f3r, $urandom, $urandom, dr, dv);
            end else begin
                do_instr(1'b1, 1'b1, 3'($urandom), $urandom, $urandom, dr, dv);
            end
        end

        do_instr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
